// File: rtl/mbt_pkg.sv
// Constants shared by the Mandelbrot engine, the frame-buffer write packer and
// the read-side address decoder.
package mbt_pkg;

    localparam int H_RES          = 800;
    localparam int V_RES          = 600;
    localparam int PIX_COUNT      = H_RES * V_RES;
    localparam int BYTES_PER_WORD = 4;
    localparam int DATA_W         = 8 * BYTES_PER_WORD;
    localparam int LANE_W         = $clog2(BYTES_PER_WORD);
    localparam int IDX_W          = 19;
    localparam int ADDR_W         = IDX_W - LANE_W;

    function automatic logic [BYTES_PER_WORD-1:0] lane_mask(input logic [LANE_W-1:0] lane);
        return BYTES_PER_WORD'(1) << lane;
    endfunction

endpackage

// File: rtl/pixel_write_packer_if.sv
// Pixel stream in from the iteration engine and BRAM port-A write bus out.
// Valid/ready: a pixel transfers on a rising clk edge where i_valid && o_ready.
interface pixel_write_packer_if;
    import mbt_pkg::*;

    logic                      i_valid;
    logic                      o_ready;
    logic [IDX_W-1:0]          i_idx;
    logic [7:0]                i_iter;
    logic                      i_flush;
    logic [BYTES_PER_WORD-1:0] o_wea;
    logic [ADDR_W-1:0]         o_addr;
    logic [DATA_W-1:0]         o_dout;

    modport slave (
        input  i_valid, i_idx, i_iter, i_flush,
        output o_ready, o_wea, o_addr, o_dout
    );

    modport master (
        output i_valid, i_idx, i_iter, i_flush,
        input  o_ready, o_wea, o_addr, o_dout
    );

endinterface

// File: rtl/pixel_write_packer.sv
// Packs up to four consecutive 8-bit pixels into one 32-bit BRAM write with
// byte enables; partial words leave on word change or flush.
module pixel_write_packer
    import mbt_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    pixel_write_packer_if.slave  bus,
    output logic                 o_busy,
    output logic                 o_range_err,
    output logic                 o_dbg_drain
);

    typedef enum logic {ST_ACCUM = 1'b0, ST_DRAIN = 1'b1} state_t;

    state_t                    r_state, w_nxt_state;
    logic [ADDR_W-1:0]         r_stg_addr, w_nxt_stg_addr;
    logic [DATA_W-1:0]         r_stg_data, w_nxt_stg_data;
    logic [BYTES_PER_WORD-1:0] r_stg_mask, w_nxt_stg_mask;
    logic [BYTES_PER_WORD-1:0] r_wea, w_nxt_wea;
    logic [ADDR_W-1:0]         r_addr, w_nxt_addr;
    logic [DATA_W-1:0]         r_dout, w_nxt_dout;
    logic                      r_range_err, w_nxt_range_err;

    logic                      w_ready;
    logic                      w_in_range;
    logic                      w_take;
    logic                      w_same;
    logic [LANE_W-1:0]         w_lane;
    logic [ADDR_W-1:0]         w_word;
    logic [BYTES_PER_WORD-1:0] w_lane_mask;
    logic [BYTES_PER_WORD-1:0] w_mrg_mask;
    logic [DATA_W-1:0]         w_mrg_data;
    logic [DATA_W-1:0]         w_new_data;

    assign w_ready     = !rst && (r_state == ST_ACCUM);
    assign w_lane      = bus.i_idx[LANE_W-1:0];
    assign w_word      = bus.i_idx[IDX_W-1:LANE_W];
    assign w_in_range  = bus.i_idx < IDX_W'(PIX_COUNT);
    assign w_take      = bus.i_valid && w_ready && w_in_range;
    assign w_same      = (r_stg_mask == '0) || (r_stg_addr == w_word);
    assign w_lane_mask = lane_mask(w_lane);
    assign w_mrg_mask  = r_stg_mask | w_lane_mask;
    assign w_new_data  = {{(DATA_W-8){1'b0}}, bus.i_iter} << {w_lane, 3'b000};

    // Unstaged bytes read as zero so a fresh word never carries stale data.
    always_comb begin
        w_mrg_data = '0;
        for (int k = 0; k < BYTES_PER_WORD; k++) begin
            if (w_lane == LANE_W'(k))
                w_mrg_data[8*k +: 8] = bus.i_iter;
            else if (r_stg_mask[k])
                w_mrg_data[8*k +: 8] = r_stg_data[8*k +: 8];
        end
    end

    always_comb begin
        w_nxt_state     = r_state;
        w_nxt_stg_addr  = r_stg_addr;
        w_nxt_stg_data  = r_stg_data;
        w_nxt_stg_mask  = r_stg_mask;
        w_nxt_wea       = '0;
        w_nxt_addr      = r_addr;
        w_nxt_dout      = r_dout;
        w_nxt_range_err = r_range_err | (bus.i_valid && w_ready && !w_in_range);

        case (r_state)
            ST_ACCUM: begin
                if (w_take && w_same) begin
                    if (w_mrg_mask == '1 || bus.i_flush) begin
                        w_nxt_wea      = w_mrg_mask;
                        w_nxt_addr     = w_word;
                        w_nxt_dout     = w_mrg_data;
                        w_nxt_stg_mask = '0;
                    end else begin
                        w_nxt_stg_addr = w_word;
                        w_nxt_stg_data = w_mrg_data;
                        w_nxt_stg_mask = w_mrg_mask;
                    end
                end else if (w_take) begin
                    // Word change: old word leaves now, new pixel takes its place.
                    w_nxt_wea      = r_stg_mask;
                    w_nxt_addr     = r_stg_addr;
                    w_nxt_dout     = r_stg_data;
                    w_nxt_stg_addr = w_word;
                    w_nxt_stg_data = w_new_data;
                    w_nxt_stg_mask = w_lane_mask;
                    if (bus.i_flush)
                        w_nxt_state = ST_DRAIN;
                end else if (bus.i_flush && r_stg_mask != '0) begin
                    w_nxt_wea      = r_stg_mask;
                    w_nxt_addr     = r_stg_addr;
                    w_nxt_dout     = r_stg_data;
                    w_nxt_stg_mask = '0;
                end
            end
            ST_DRAIN: begin
                w_nxt_wea      = r_stg_mask;
                w_nxt_addr     = r_stg_addr;
                w_nxt_dout     = r_stg_data;
                w_nxt_stg_mask = '0;
                w_nxt_state    = ST_ACCUM;
            end
            default: w_nxt_state = ST_ACCUM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_ACCUM;
            r_stg_addr  <= '0;
            r_stg_data  <= '0;
            r_stg_mask  <= '0;
            r_wea       <= '0;
            r_addr      <= '0;
            r_dout      <= '0;
            r_range_err <= 1'b0;
        end else begin
            r_state     <= w_nxt_state;
            r_stg_addr  <= w_nxt_stg_addr;
            r_stg_data  <= w_nxt_stg_data;
            r_stg_mask  <= w_nxt_stg_mask;
            r_wea       <= w_nxt_wea;
            r_addr      <= w_nxt_addr;
            r_dout      <= w_nxt_dout;
            r_range_err <= w_nxt_range_err;
        end
    end

    assign bus.o_ready  = w_ready;
    assign bus.o_wea    = r_wea;
    assign bus.o_addr   = r_addr;
    assign bus.o_dout   = r_dout;
    assign o_busy       = (r_stg_mask != '0) || (r_wea != '0) || (r_state == ST_DRAIN);
    assign o_range_err  = r_range_err;
    assign o_dbg_drain  = (r_state == ST_DRAIN);

endmodule

// File: tb/tb_pixel_write_packer.sv
// Directed bench for pixel_write_packer: a word-level model predicts every
// post-edge output; a per-cycle compare process checks the DUT against it.
module tb_pixel_write_packer;
    import mbt_pkg::*;

    localparam int REC_W = 3 + 4 + ADDR_W + 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pixel_write_packer_if pif();
    logic busy, range_err, dbg_drain;

    pixel_write_packer dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (pif),
        .o_busy      (busy),
        .o_range_err (range_err),
        .o_dbg_drain (dbg_drain)
    );

    // Model: staged word as four optional bytes, plus a pending second write.
    int          m_word;
    logic [7:0]  m_byte [4];
    bit          m_have [4];
    bit          m_drain;
    bit          m_err;

    logic [REC_W-1:0] exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;
    int n_writes = 0;
    logic [3:0]        last_wea;
    logic [ADDR_W-1:0] last_addr;
    logic [31:0]       last_dout;
    bit saw_w25 = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] byte_mask(input logic [3:0] wea);
        logic [31:0] m = '0;
        for (int k = 0; k < 4; k++) if (wea[k]) m[8*k +: 8] = 8'hFF;
        return m;
    endfunction

    function automatic bit m_any();
        return m_have[0] | m_have[1] | m_have[2] | m_have[3];
    endfunction

    function automatic bit m_full();
        return m_have[0] & m_have[1] & m_have[2] & m_have[3];
    endfunction

    task automatic m_take_word(output logic [3:0] w, output logic [ADDR_W-1:0] a, output logic [31:0] d);
        w = '0;
        d = '0;
        a = ADDR_W'(m_word);
        for (int k = 0; k < 4; k++) begin
            if (m_have[k]) begin
                w[k] = 1'b1;
                d[8*k +: 8] = m_byte[k];
            end
            m_have[k] = 0;
        end
    endtask

    task automatic m_place(input int wd, input int ln, input logic [7:0] it);
        m_word = wd;
        m_byte[ln] = it;
        m_have[ln] = 1;
    endtask

    task automatic model_step(input bit r, input bit v, input int idx, input logic [7:0] it, input bit fl);
        logic [3:0] w = '0;
        logic [ADDR_W-1:0] a = '0;
        logic [31:0] d = '0;
        bit rdy, bsy;
        if (r) begin
            for (int k = 0; k < 4; k++) m_have[k] = 0;
            m_drain = 0;
            m_err = 0;
            rdy = 0;
            bsy = 0;
        end else begin
            if (m_drain) begin
                m_take_word(w, a, d);
                m_drain = 0;
            end else if (v && idx >= PIX_COUNT) begin
                m_err = 1;
                if (fl && m_any()) m_take_word(w, a, d);
            end else if (v) begin
                if (m_any() && (idx / 4) != m_word) begin
                    m_take_word(w, a, d);
                    m_place(idx / 4, idx % 4, it);
                    if (fl) m_drain = 1;
                end else begin
                    m_place(idx / 4, idx % 4, it);
                    if (m_full() || fl) m_take_word(w, a, d);
                end
            end else if (fl && m_any()) begin
                m_take_word(w, a, d);
            end
            rdy = !m_drain;
            bsy = m_any() || (w != 0) || m_drain;
        end
        exp_q.push_back({rdy, bsy, m_err, w, a, d});
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [REC_W-1:0] rec;
            logic e_rdy, e_bsy, e_err;
            logic [3:0] e_wea;
            logic [ADDR_W-1:0] e_addr;
            logic [31:0] e_dout;
            rec = exp_q.pop_front();
            {e_rdy, e_bsy, e_err, e_wea, e_addr, e_dout} = rec;
            check("o_ready", 64'(pif.o_ready), 64'(e_rdy));
            check("o_busy", 64'(busy), 64'(e_bsy));
            check("o_range_err", 64'(range_err), 64'(e_err));
            check("o_wea", 64'(pif.o_wea), 64'(e_wea));
            if (e_wea != 0) begin
                check("o_addr", 64'(pif.o_addr), 64'(e_addr));
                check("o_dout", 64'(pif.o_dout & byte_mask(e_wea)), 64'(e_dout));
            end
        end
        if (pif.o_wea != 0) begin
            n_writes++;
            last_wea  = pif.o_wea;
            last_addr = pif.o_addr;
            last_dout = pif.o_dout;
            if (pif.o_addr == ADDR_W'(25)) saw_w25 = 1;
        end
    end

    task automatic step(input bit r, input bit v, input int idx, input logic [7:0] it, input bit fl);
        rst         = r;
        pif.i_valid = v;
        pif.i_idx   = IDX_W'(idx);
        pif.i_iter  = it;
        pif.i_flush = fl;
        model_step(r, v, idx, it, fl);
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic idle();
        step(0, 0, 0, 8'h00, 0);
    endtask

    initial begin
        int w0;
        pif.i_valid = 0;
        pif.i_idx   = '0;
        pif.i_iter  = '0;
        pif.i_flush = 0;
        for (int k = 0; k < 4; k++) begin
            m_have[k] = 0;
            m_byte[k] = '0;
        end
        m_word  = 0;
        m_drain = 0;
        m_err   = 0;
        #2;

        step(1, 0, 0, 8'h00, 0);
        step(1, 0, 0, 8'h00, 0);
        check("reset wea", 64'(pif.o_wea), 64'h0);
        check("reset ready", 64'(pif.o_ready), 64'h0);
        idle();
        check("ready after reset", 64'(pif.o_ready), 64'h1);

        // Four lanes of word 0 back-to-back.
        w0 = n_writes;
        step(0, 1, 0, 8'h11, 0);
        step(0, 1, 1, 8'h22, 0);
        step(0, 1, 2, 8'h33, 0);
        step(0, 1, 3, 8'h44, 0);
        check("full word count", 64'(n_writes - w0), 64'd1);
        check("full word wea", 64'(last_wea), 64'hF);
        check("full word addr", 64'(last_addr), 64'h0);
        check("full word dout", 64'(last_dout), 64'h44332211);
        idle();

        // Word change emits the old partial; flush emits the new one.
        step(0, 1, 5, 8'hAA, 0);
        step(0, 1, 9, 8'hBB, 0);
        check("chg wea", 64'(last_wea), 64'h2);
        check("chg addr", 64'(last_addr), 64'h1);
        check("chg byte", 64'(last_dout[15:8]), 64'hAA);
        step(0, 0, 0, 8'h00, 1);
        check("flush wea", 64'(last_wea), 64'h2);
        check("flush addr", 64'(last_addr), 64'h2);
        check("flush byte", 64'(last_dout[15:8]), 64'hBB);
        idle();
        check("idle busy", 64'(busy), 64'h0);

        // Repeated lane: last write wins.
        w0 = n_writes;
        step(0, 1, 8, 8'h01, 0);
        step(0, 1, 8, 8'h02, 0);
        step(0, 0, 0, 8'h00, 1);
        check("overwrite count", 64'(n_writes - w0), 64'd1);
        check("overwrite wea", 64'(last_wea), 64'h1);
        check("overwrite byte", 64'(last_dout[7:0]), 64'h02);
        idle();

        // Flush with a pixel for a different word needs two writes.
        step(0, 1, 12, 8'h7F, 0);
        step(0, 1, 20, 8'h80, 1);
        check("two-write first addr", 64'(last_addr), 64'h3);
        check("two-write stall", 64'(pif.o_ready), 64'h0);
        idle();
        check("two-write second addr", 64'(last_addr), 64'h5);
        check("two-write second byte", 64'(last_dout[7:0]), 64'h80);
        check("two-write ready back", 64'(pif.o_ready), 64'h1);
        idle();

        // Last valid pixel and first out-of-range one.
        step(0, 1, PIX_COUNT - 1, 8'h5A, 1);
        check("last pixel addr", 64'(last_addr), 64'(119999));
        check("last pixel wea", 64'(last_wea), 64'h8);
        w0 = n_writes;
        step(0, 1, PIX_COUNT, 8'hEE, 0);
        idle();
        check("range no write", 64'(n_writes - w0), 64'd0);
        check("range err set", 64'(range_err), 64'h1);
        step(0, 1, 40, 8'hC1, 0);
        step(0, 1, 41, 8'hC2, 0);
        step(0, 1, 42, 8'hC3, 0);
        step(0, 1, 43, 8'hC4, 0);
        check("range err sticky", 64'(range_err), 64'h1);
        check("packed after err", 64'(last_dout), 64'hC4C3C2C1);
        step(1, 0, 0, 8'h00, 0);
        idle();
        check("range err cleared", 64'(range_err), 64'h0);

        // Reset drops a staged partial word silently.
        step(0, 1, 100, 8'h64, 0);
        step(0, 1, 101, 8'h65, 0);
        step(1, 0, 0, 8'h00, 0);
        idle();
        step(0, 0, 0, 8'h00, 1);
        idle();
        check("no word 25 write", 64'(saw_w25), 64'h0);
        check("ready after rst", 64'(pif.o_ready), 64'h1);
        check("busy after rst", 64'(busy), 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
